// File: rtl/aes_selftest_sequencer_if.sv
// Handshake bundle between the self-test sequencer, its requester and the AES wrapper.
interface aes_selftest_sequencer_if;
  // Requester side
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] result;
  logic       timeout;
  // Wrapper side
  logic       wrap_reset;
  logic [1:0] wrap_nk;
  logic       wrap_enc_ok;
  logic       wrap_dec_ok;
  logic       wrap_done;

  // Sequencer view
  modport master (
    input  start, wrap_enc_ok, wrap_dec_ok, wrap_done,
    output busy, done, pass, result, timeout, wrap_reset, wrap_nk
  );

  // Requester / wrapper view
  modport slave (
    output start, wrap_enc_ok, wrap_dec_ok, wrap_done,
    input  busy, done, pass, result, timeout, wrap_reset, wrap_nk
  );
endinterface

// File: rtl/aes_selftest_sequencer.sv
// Drives the AES self-checking wrapper once per key size (128/192/256), collects the
// encrypt/decrypt match flags and reports an aggregate verdict. A per-run watchdog
// catches a wrapper that never signals completion.
module aes_selftest_sequencer #(
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  aes_selftest_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] RstLast = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ToLast  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRst, StRun, StNext, StFin} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       nk_q, nk_d;
  logic             wrap_reset_q, wrap_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [5:0]       result_q, result_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       res_idx;

  // Result bit pair for the current key size: enc at 2*nk, dec at 2*nk+1.
  assign res_idx = {nk_q, 1'b0};

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nk_d         = nk_q;
    wrap_reset_d = wrap_reset_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    result_d     = result_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      StIdle: begin
        wrap_reset_d = 1'b1;
        // A start coinciding with the done pulse is not a new request.
        if (bus.start && !done_q) begin
          result_d  = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          nk_d      = 2'b00;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StRst;
        end
      end
      StRst: begin
        if (cnt_q == RstLast) begin
          wrap_reset_d = 1'b0;
          cnt_d        = '0;
          state_d      = StRun;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        cnt_d = cnt_q + CNT_W'(1);
        // First RUN cycle (cnt_q == 0) ignores a done left over from the previous mode.
        if ((cnt_q != '0) && bus.wrap_done) begin
          result_d[res_idx]        = bus.wrap_enc_ok;
          result_d[res_idx + 3'd1] = bus.wrap_dec_ok;
          state_d                  = StNext;
        end else if (cnt_q == ToLast) begin
          timeout_d = 1'b1;
          state_d   = StNext;
        end
      end
      StNext: begin
        wrap_reset_d = 1'b1;
        cnt_d        = '0;
        if (nk_q == 2'b10) begin
          state_d = StFin;
        end else begin
          nk_d    = nk_q + 2'b01;
          state_d = StRst;
        end
      end
      StFin: begin
        done_d  = 1'b1;
        pass_d  = &result_q;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset holds the wrapper in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      nk_q         <= 2'b00;
      wrap_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      result_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nk_q         <= nk_d;
      wrap_reset_q <= wrap_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.wrap_reset = wrap_reset_q;
  assign bus.wrap_nk    = nk_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.result     = result_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_aes_selftest_sequencer.sv
// Directed bench: a behavioural wrapper model plus a table of sweep scenarios.
module tb_aes_selftest_sequencer;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  aes_selftest_sequencer_if bus ();

  aes_selftest_sequencer #(
    .RST_CYCLES    (2),
    .TIMEOUT_CYCLES(16),
    .CNT_W         (13)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Wrapper model configuration: mode 0 = done on 2nd RUN cycle, 1 = done held high,
  // 2 = done on the 16th RUN cycle (coincides with the watchdog).
  int         cfg_mode    = 0;
  int         cfg_fail_nk = -1;
  int         cfg_hang_nk = -1;
  int         rc          = 0;
  logic       prev_wr     = 1'b1;
  logic [5:0] nk_seq      = '0;

  typedef struct {
    string      name;
    int         mode;
    int         fail_nk;
    int         hang_nk;
    bit         inj_start;
    logic [5:0] res;
    logic       pass;
    logic       tout;
    int         cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wrapper model and Nk-sequence monitor; changes inputs away from the rising edge.
  always @(negedge clk_i) begin
    int nk_i;
    if (bus.wrap_reset) rc = 0;
    else rc = rc + 1;
    if (prev_wr && !bus.wrap_reset) nk_seq = {bus.wrap_nk, nk_seq[5:2]};
    prev_wr = bus.wrap_reset;
    nk_i = int'(bus.wrap_nk);
    bus.wrap_enc_ok = 1'b1;
    bus.wrap_dec_ok = (nk_i != cfg_fail_nk);
    case (cfg_mode)
      1:       bus.wrap_done = 1'b1;
      2:       bus.wrap_done = (rc == 16);
      default: bus.wrap_done = (rc == 2);
    endcase
    if (nk_i == cfg_hang_nk) bus.wrap_done = 1'b0;
  end

  task automatic run_sweep(input vec_t v);
    int n;
    bit got;
    cfg_mode    = v.mode;
    cfg_fail_nk = v.fail_nk;
    cfg_hang_nk = v.hang_nk;
    nk_seq      = '0;
    @(negedge clk_i);
    bus.start = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start = 1'b0;
    check({v.name, " busy after start"}, 32'(bus.busy), 32'd1);
    check({v.name, " result cleared"}, 32'(bus.result), 32'd0);
    check({v.name, " timeout cleared"}, 32'(bus.timeout), 32'd0);
    n   = 0;
    got = 1'b0;
    while (n < 200 && !got) begin
      bus.start = (v.inj_start && n == 3);
      @(posedge clk_i);
      #1;
      n++;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    check({v.name, " done seen"}, 32'(got), 32'd1);
    check({v.name, " cycles"}, 32'(n), 32'(v.cyc));
    check({v.name, " result"}, 32'(bus.result), 32'(v.res));
    check({v.name, " pass"}, 32'(bus.pass), 32'(v.pass));
    check({v.name, " timeout"}, 32'(bus.timeout), 32'(v.tout));
    check({v.name, " nk order"}, 32'(nk_seq), 32'h24);
    check({v.name, " busy at done"}, 32'(bus.busy), 32'd0);
    // Start in the done-pulse cycle must be ignored.
    bus.start = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start = 1'b0;
    check({v.name, " start at done ignored"}, 32'(bus.busy), 32'd0);
    check({v.name, " done is one cycle"}, 32'(bus.done), 32'd0);
    check({v.name, " pass sticky"}, 32'(bus.pass), 32'(v.pass));
  endtask

  initial begin
    int n;
    bus.start       = 1'b0;
    bus.wrap_done   = 1'b0;
    bus.wrap_enc_ok = 1'b0;
    bus.wrap_dec_ok = 1'b0;

    //        name        mode fail hang inj  result      pass  tout cyc
    vecs[0] = '{"allpass",  0,  -1,  -1, 1'b0, 6'b111111, 1'b1, 1'b0, 16};
    vecs[1] = '{"dec192",   0,   1,  -1, 1'b0, 6'b110111, 1'b0, 1'b0, 16};
    vecs[2] = '{"hang256",  0,  -1,   2, 1'b0, 6'b001111, 1'b0, 1'b1, 30};
    vecs[3] = '{"stale",    1,  -1,  -1, 1'b0, 6'b111111, 1'b1, 1'b0, 16};
    vecs[4] = '{"coincide", 2,  -1,  -1, 1'b0, 6'b111111, 1'b1, 1'b0, 58};
    vecs[5] = '{"busystart",0,  -1,  -1, 1'b1, 6'b111111, 1'b1, 1'b0, 16};

    #12;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst wrap_reset", 32'(bus.wrap_reset), 32'd1);
    check("rst wrap_nk", 32'(bus.wrap_nk), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst pass", 32'(bus.pass), 32'd0);
    check("rst result", 32'(bus.result), 32'd0);
    check("rst timeout", 32'(bus.timeout), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 6; i++) run_sweep(vecs[i]);

    // Asynchronous reset during the 192-bit run.
    cfg_mode    = 0;
    cfg_fail_nk = -1;
    cfg_hang_nk = -1;
    @(negedge clk_i);
    bus.start = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (n < 100 && !(bus.wrap_nk == 2'b01 && !bus.wrap_reset)) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("midrst reached nk=01 run", 32'(n < 100), 32'd1);
    check("midrst partial result", 32'(bus.result), 32'h03);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst wrap_reset", 32'(bus.wrap_reset), 32'd1);
    check("midrst wrap_nk", 32'(bus.wrap_nk), 32'd0);
    check("midrst result", 32'(bus.result), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_sweep(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_selftest_sequencer.md
Name: aes_selftest_sequencer

Overview:
- On-chip driver and checker for the AES self-checking wrapper (clk, active-high reset, 2-bit Nk select, encrypt-ok / decrypt-ok flags, done strobe).
- Runs the wrapper once per key size (AES-128, 192, 256), collects the per-mode pass flags and reports an aggregate verdict.
- Replaces the simulation-only stimulus so the self-test runs in silicon or FPGA.
- A watchdog per run catches a hung wrapper.

Parameters:
- RST_CYCLES, 2, cycles wrap_reset is held high before each run (1..15).
- TIMEOUT_CYCLES, 4096, max cycles from wrap_reset release to wrap_done before the run is declared failed (>=16).
- CNT_W, 13, width of the shared cycle counter; must hold max(RST_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  single-cycle request to begin a self-test sweep; ignored while busy
- wrap_reset  out  1  active-high reset to the wrapper
- wrap_nk  out  2  key-size select to the wrapper: 00=128, 01=192, 10=256
- wrap_enc_ok  in  1  wrapper encrypt-match flag, valid when wrap_done=1
- wrap_dec_ok  in  1  wrapper decrypt-match flag, valid when wrap_done=1
- wrap_done  in  1  wrapper completion, level or pulse
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at end of sweep
- pass  out  1  sticky; 1 iff all six result bits are 1; valid from the done pulse until the next start
- result  out  6  {dec256,enc256,dec192,enc192,dec128,enc128}; sticky until the next start
- timeout  out  1  sticky; set if any run hit TIMEOUT_CYCLES

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; wrap_reset=1 (wrapper held in reset while idle); wrap_nk=00.
  - busy=0, done=0, pass=0, result=0, timeout=0, counter=0.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - wrap_reset=1.
  - On start=1: clear result, pass and timeout; wrap_nk<=00; counter<=0; busy<=1; go to RST.
- RST:
  - wrap_reset=1; counter increments each cycle.
  - When counter==RST_CYCLES-1: wrap_reset<=0, counter<=0, go to RUN.
  - wrap_reset is therefore high for exactly RST_CYCLES cycles after IDLE→RST.
- RUN:
  - wrap_reset=0; counter increments.
  - wrap_done is sampled only in RUN, starting from the 2nd RUN cycle. The first RUN cycle ignores any done left stale from the previous mode.
  - On wrap_done=1: latch wrap_enc_ok/wrap_dec_ok into the two result bits selected by wrap_nk; go to NEXT.
  - Else if counter==TIMEOUT_CYCLES-1: both bits for this mode stay 0; timeout<=1; go to NEXT.
  - If wrap_done and the timeout arrive in the same cycle, done wins: latch the flags, timeout not set.
- NEXT (1 cycle):
  - wrap_reset<=1; counter<=0.
  - If wrap_nk==10: go to FIN.
  - Else wrap_nk<=wrap_nk+1 and go to RST.
  - wrap_nk never takes the value 11.
- FIN (1 cycle):
  - done<=1 for one cycle; pass<=&result (including the bits latched this sweep); busy<=0; go to IDLE.
  - wrap_reset stays 1.
- start while busy: ignored, no restart.
- start in the same cycle as the done pulse: ignored. A new sweep requires start in IDLE.
- reset asserted mid-sweep: immediate return to the reset values. Partial results are discarded and the wrapper is reset via wrap_reset=1.
- Latency with an ideal wrapper (done on the 2nd RUN cycle), per mode: RST_CYCLES + 2 + 1 cycles.
- Full sweep: start → done pulse = 1 + 3*(RST_CYCLES+3) cycles; 16 cycles at defaults.

Test Plan:
- All pass: model wrapper asserts done with enc_ok=dec_ok=1 on the 2nd RUN cycle for each Nk. Required: wrap_nk visits 00,01,10 in order; done pulses exactly 16 cycles after start; result=6'b111111; pass=1; timeout=0.
- Single failure: model returns dec_ok=0 only for Nk=01. Required: result=6'b110111, pass=0, timeout=0.
- Timeout: with TIMEOUT_CYCLES=16, model never asserts done for Nk=10. Required: mode-2 bits=00, timeout=1, pass=0, result=6'b001111; done still pulses once.
- Stale done: model holds wrap_done=1 continuously. Required: the first RUN cycle of each mode is ignored; each mode completes on its 2nd RUN cycle; no mode skipped.
- Reset mid-sweep: pull reset low during the RUN of Nk=01. Required: asynchronously busy=0, wrap_reset=1, wrap_nk=00, result=0. After release plus start, a clean full sweep passes.
- Busy-start and coincident events: pulse start during RUN → no restart. Assert done and timeout in the same cycle → flags latched, timeout=0.
